dff_upset_counter_link: RTL and testbench

Parametrised successor to the 19-channel DFF test top. It watches N_CH DFF outputs from the 12 nm test die, compares each against a static expected level, and counts upsets (mismatch onsets) per channel in saturating counters. On a save request from the Raspberry Pi it snapshots and clears all counters atomically. It then shifts the snapshot, prefixed by a frame sequence number, out to the Pi one bit per Pi-driven data clock. It sits between the DUT pin bank and the Pi GPIO link in the FPGA top level.

---
 rtl/dff_upset_counter_link_if.sv | 12 +
 rtl/dff_upset_counter_link.sv | 67 ++++++
 tb/tb_dff_upset_counter_link.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dff_upset_counter_link_if.sv
// dff_upset_counter_link_if: DUT pin bank plus Pi GPIO link bundle
interface dff_upset_counter_link_if #(parameter int N_CH = 19);
  logic [N_CH-1:0] dut_q;
  logic [N_CH-1:0] expected;
  logic save_data;
  logic data_clk;
  logic data_out;
  logic frame_ready;
  logic upset;
  modport master (output dut_q, expected, save_data, data_clk, input data_out, frame_ready, upset);
  modport slave (input dut_q, expected, save_data, data_clk, output data_out, frame_ready, upset);
endinterface

// File: rtl/dff_upset_counter_link.sv
// dff_upset_counter_link: per-channel DFF upset counters, snapshotted and shifted out to the Pi
module dff_upset_counter_link #(
  parameter int N_CH = 19,
  parameter int CNT_W = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  dff_upset_counter_link_if.slave link
);
  localparam int FRAME_W = 8 + N_CH * CNT_W;
  localparam int IDX_W = $clog2(FRAME_W + 1);
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  logic [N_CH+1:0] sync_r [SYNC_STAGES];
  logic [N_CH+1:0] sync_q;
  logic save_d, dclk_d, save_edge, shift_edge, en, ready, upset_r;
  logic [N_CH-1:0] m, m_d, up;
  logic [N_CH-1:0][CNT_W-1:0] cnt;
  logic [7:0] seq;
  logic [FRAME_W-1:0] sr;
  logic [IDX_W-1:0] idx;
  logic [WARM_W-1:0] warm;
  assign sync_q = sync_r[SYNC_STAGES-1];
  assign m = sync_q[N_CH-1:0] ^ link.expected;
  assign en = warm == WARM_W'(SYNC_STAGES + 1);
  assign up = m & ~m_d & {N_CH{en}};
  assign save_edge = sync_q[N_CH] & ~save_d;
  assign shift_edge = sync_q[N_CH+1] & ~dclk_d & ready;
  assign link.data_out = sr[FRAME_W-1];
  assign link.frame_ready = ready;
  assign link.upset = upset_r;
  // m_d follows m during warm-up so reset-zero synchroniser contents never count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
      save_d <= 1'b0;
      dclk_d <= 1'b0;
      m_d <= '0;
      warm <= '0;
      upset_r <= 1'b0;
      cnt <= '0;
      seq <= '0;
      sr <= '0;
      idx <= '0;
      ready <= 1'b0;
    end else begin
      sync_r[0] <= {link.data_clk, link.save_data, link.dut_q};
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
      save_d <= sync_q[N_CH];
      dclk_d <= sync_q[N_CH+1];
      m_d <= m;
      if (!en) warm <= warm + WARM_W'(1);
      upset_r <= |up;
      for (int i = 0; i < N_CH; i++)
        cnt[i] <= save_edge ? CNT_W'(up[i]) : (up[i] && !(&cnt[i])) ? cnt[i] + CNT_W'(1) : cnt[i];
      if (save_edge) begin
        sr <= {seq, cnt};
        seq <= seq + 8'd1;
        ready <= 1'b1;
        idx <= '0;
      end else if (shift_edge) begin
        sr <= sr << 1;
        idx <= idx + IDX_W'(1);
        ready <= idx != IDX_W'(FRAME_W - 1);
      end
    end
endmodule

// File: tb/tb_dff_upset_counter_link.sv
// tb_dff_upset_counter_link: directed plus random upset/frame checks against a counting model
module tb_dff_upset_counter_link;
  localparam int N = 19, W = 16, S = 2, FW = 8 + N * W;
  localparam int SN = 2, SW = 4, SFW = 8 + SN * SW;
  logic clk = 1'b0, rst = 1'b1;
  always #10 clk = ~clk;
  dff_upset_counter_link_if #(.N_CH(N)) lk ();
  dff_upset_counter_link_if #(.N_CH(SN)) ls ();
  dff_upset_counter_link #(.N_CH(N), .CNT_W(W), .SYNC_STAGES(S)) dut (.clk(clk), .rst(rst), .link(lk));
  dff_upset_counter_link #(.N_CH(SN), .CNT_W(SW), .SYNC_STAGES(S)) dut_sat (.clk(clk), .rst(rst), .link(ls));
  int total = 0, bad = 0;
  int mcnt [N];
  bit mprev [N];
  int mseq;
  logic [FW-1:0] got, want;
  logic [SFW-1:0] sg;
  logic [N-1:0] base;
  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] f = FW'(8'(mseq));
    for (int i = N - 1; i >= 0; i--) f = {f[FW-W-1:0], W'(mcnt[i])};
    return f;
  endfunction
  task automatic model_reset();
    mseq = 0;
    for (int i = 0; i < N; i++) begin
      mcnt[i] = 0;
      mprev[i] = lk.dut_q[i] ^ lk.expected[i];
    end
  endtask
  task automatic save_model();
    want = model_frame();
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    mseq = (mseq + 1) % 256;
  endtask
  task automatic set_q(input logic [N-1:0] v);
    int pulses = 0;
    int onset = 0;
    for (int i = 0; i < N; i++) begin
      if ((v[i] ^ lk.expected[i]) && !mprev[i]) begin
        onset = 1;
        if (mcnt[i] < 2 ** W - 1) mcnt[i]++;
      end
      mprev[i] = v[i] ^ lk.expected[i];
    end
    lk.dut_q = v;
    repeat (3) begin
      @(negedge clk);
      pulses += int'(lk.upset);
    end
    check("upset pulse", FW'(pulses), FW'(onset));
  endtask
  task automatic raise_save();
    logic was = lk.frame_ready;
    lk.save_data = 1'b1;
    repeat (2) @(negedge clk);
    if (!was) check("save not early", FW'(lk.frame_ready), FW'(0));
    @(negedge clk);
    check("save ready", FW'(lk.frame_ready), FW'(1));
    check("first bit", FW'(lk.data_out), FW'(want[FW-1]));
    lk.save_data = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic do_save();
    save_model();
    raise_save();
  endtask
  task automatic pulse_dclk();
    lk.data_clk = 1'b1;
    repeat (5) @(negedge clk);
    lk.data_clk = 1'b0;
    repeat (5) @(negedge clk);
  endtask
  task automatic read_frame(input int n);
    int rc = 0;
    got = '0;
    for (int i = 0; i < n; i++) begin
      got = {got[FW-2:0], lk.data_out};
      rc += int'(lk.frame_ready);
      pulse_dclk();
    end
    check("ready while shifting", FW'(rc), FW'(n));
    if (n == FW) begin
      check("ready after frame", FW'(lk.frame_ready), FW'(0));
      check("data_out after frame", FW'(lk.data_out), FW'(0));
    end
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    lk.expected = '1;
    lk.dut_q = '1;
    lk.save_data = 1'b0;
    lk.data_clk = 1'b0;
    ls.expected = '0;
    ls.dut_q = '0;
    ls.save_data = 1'b0;
    ls.data_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("reset data_out", FW'(lk.data_out), FW'(0));
    check("reset ready", FW'(lk.frame_ready), FW'(0));
    check("reset upset", FW'(lk.upset), FW'(0));
    model_reset();
    rst = 1'b0;
    repeat (8) @(negedge clk);
    do_save();
    read_frame(FW);
    check("warmup frame", got, want);
    check("warmup frame zero", got, FW'(0));
    base = '1 ^ (N'(1) << 18);
    set_q(base);
    repeat (3) begin
      set_q(base ^ N'(1));
      set_q(base);
    end
    repeat (1000) @(negedge clk);
    do_save();
    read_frame(FW);
    check("single frame", got, want);
    check("cnt0 field", FW'(got[W-1:0]), FW'(3));
    check("cnt18 field", FW'(got[18*W +: W]), FW'(1));
    do_save();
    read_frame(FW);
    check("second frame", got, want);
    for (int p = 0; p < 40; p++) begin
      ls.dut_q = 2'b10;
      repeat (2) @(negedge clk);
      ls.dut_q = 2'b00;
      repeat (2) @(negedge clk);
    end
    ls.save_data = 1'b1;
    repeat (3) @(negedge clk);
    check("sat ready", FW'(ls.frame_ready), FW'(1));
    ls.save_data = 1'b0;
    sg = '0;
    for (int i = 0; i < SFW; i++) begin
      sg = {sg[SFW-2:0], ls.data_out};
      ls.data_clk = 1'b1;
      repeat (5) @(negedge clk);
      ls.data_clk = 1'b0;
      repeat (5) @(negedge clk);
    end
    check("sat frame", FW'(sg), FW'(16'h00F0));
    set_q('1);
    set_q('1 ^ (N'(1) << 7));
    set_q('1);
    save_model();
    mcnt[7] = 1;
    mprev[7] = 1'b1;
    lk.dut_q = '1 ^ (N'(1) << 7);
    raise_save();
    read_frame(FW);
    check("coincident frame", got, want);
    check("coincident old cnt7", FW'(got[7*W +: W]), FW'(1));
    do_save();
    read_frame(FW);
    check("coincident next frame", got, want);
    check("coincident next cnt7", FW'(got[7*W +: W]), FW'(1));
    do_save();
    read_frame(40);
    check("partial frame", got, want >> (FW - 40));
    lk.data_clk = 1'b1;
    do_save();
    lk.data_clk = 1'b0;
    repeat (5) @(negedge clk);
    read_frame(FW);
    check("abort frame", got, want);
    repeat (3) pulse_dclk();
    check("extra dclk data_out", FW'(lk.data_out), FW'(0));
    check("extra dclk ready", FW'(lk.frame_ready), FW'(0));
    set_q('1 ^ N'(5));
    do_save();
    read_frame(100);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("async rst ready", FW'(lk.frame_ready), FW'(0));
    check("async rst data_out", FW'(lk.data_out), FW'(0));
    lk.expected = N'($urandom);
    lk.dut_q = N'($urandom);
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    repeat (8) @(negedge clk);
    do_save();
    read_frame(FW);
    check("post reset frame", got, want);
    check("post reset header", FW'(got[FW-1 -: 8]), FW'(0));
    repeat (3) begin
      repeat (25) set_q(N'($urandom));
      do_save();
      read_frame(FW);
      check("random frame", got, want);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
